pong_draw_sequencer: RTL and testbench
======================================

Name: pong_draw_sequencer

Overview:
- Frame-rate draw controller that sequences all pixel writes into the 320x240 vga_adapter write port (x, y, colour, plot) for the pong game.
- On each frame tick it erases the previously drawn paddles and ball with the background colour, then draws them at their new positions, one pixel per clock.
- Sits between the game-state logic (paddle/ball positions) and vga_adapter; it is the only writer of the adapter port.

Parameters:
- SCREEN_W, 320, visible width in pixels
- SCREEN_H, 240, visible height in pixels
- PADDLE_W, 4, paddle width in pixels
- PADDLE_H, 32, paddle height in pixels
- BALL_SIZE, 4, ball edge length in pixels (square)
- P1_X, 8, fixed left-edge x of player 1 paddle
- P2_X, 308, fixed left-edge x of player 2 paddle
- FG_COLOR, 3'b111, draw colour
- BG_COLOR, 3'b000, erase colour

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- frame_tick  in  1  one-cycle pulse requesting a redraw
- p1_y  in  9  player 1 paddle top y
- p2_y  in  9  player 2 paddle top y
- ball_x  in  10  ball left x
- ball_y  in  9  ball top y
- x  out  10  pixel x to vga_adapter
- y  out  9  pixel y to vga_adapter
- color  out  3  pixel colour to vga_adapter
- plot  out  1  pixel write enable
- busy  out  1  high from the cycle after an accepted tick through the done cycle
- done  out  1  one-cycle pulse at redraw completion
- overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset (rst low, async): state IDLE; x, y, color, plot, busy, done, overrun = 0; old_valid = 0; all position registers = 0.
- All outputs are registered.
- States: IDLE, ERASE_BALL, ERASE_P1, ERASE_P2, DRAW_P1, DRAW_P2, DRAW_BALL, FINISH.
- IDLE + frame_tick: latch p1_y, p2_y, ball_x, ball_y into the new_* registers.
  - Next state is ERASE_BALL if old_valid = 1, else DRAW_P1.
  - busy = 1 from the next cycle.
- Each rectangle state:
  - Scans row-major with column counter cx (0..w-1) and row counter cy (0..h-1): x = origin_x + cx, y = origin_y + cy.
  - Advances one pixel per clock. After the last pixel (cx = w-1, cy = h-1), counters clear and the FSM moves to the next state in the order listed above.
  - Erase states use the old_* origins with BG_COLOR; draw states use the new_* origins with FG_COLOR.
- Clipping: the sums are computed at 11 bits. A pixel whose x >= SCREEN_W or y >= SCREEN_H drives plot = 0 but still consumes its cycle, so cycle counts stay fixed.
- Latency:
  - First pixel (plot = 1) is presented the cycle after the tick is accepted.
  - With old_valid = 0, a redraw is 128 + 128 + 16 = 272 pixel cycles; with old_valid = 1 it is 544.
- FINISH (one cycle):
  - plot = 0, done = 1.
  - old_* <= new_*, old_valid <= 1.
  - Next state IDLE; busy drops to 0 the following cycle.
- Ball is drawn last, so it overwrites any paddle pixels it overlaps.
- frame_tick while busy is ignored (no queuing); overrun pulses the next cycle.
- Inputs changing mid-redraw have no effect; only the latched values are used.
- rst asserted mid-redraw aborts immediately. old_valid clears, so the next frame draws without erasing.

Decomposition:
- Shared package pong_pkg:
  - screen and object size constants
  - colour constants FG_COLOR/BG_COLOR
  - FSM state enum draw_state_t
- One natural sub-module: rect_scanner. Given origin, w, h and a start pulse, it produces x/y/valid/last with clipping.
- The FSM instantiates one rect_scanner and re-targets it for each state.

Test Plan:
- Reset then frame_tick with p1_y=100, p2_y=50, ball=(160,120):
  - first plot at (8,100) colour 111 one cycle after the tick;
  - exactly 272 plot cycles;
  - done pulses at cycle 273;
  - no BG writes.
- Second tick with p1_y=104:
  - first 16 plots are BG at ball (160..163, 120..123);
  - 544 total plot cycles;
  - P1 draw starts at (8,104).
- Clipping, ball=(318,238):
  - ball draw yields only 4 plots with plot=1, at (318..319, 238..239);
  - state duration still 16 cycles.
- frame_tick pulsed 10 cycles into a redraw: overrun pulses once, pixel sequence unchanged, done timing unchanged.
- rst low at pixel 50 of DRAW_P1:
  - all outputs 0 within the reset cycle;
  - next tick draws without an erase phase (272 cycles).
- Overlap, ball=(8,100) with p1_y=100: final plotted colour at (8,100) is 111 and is written last, during DRAW_BALL.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants, state encoding and small helpers for the pong draw path.
// Everything here is sized to the vga_adapter port widths so comparisons stay width-clean.
package pong_pkg;

  localparam logic [10:0] SCREEN_W  = 11'd320;
  localparam logic [10:0] SCREEN_H  = 11'd240;
  localparam logic [5:0]  PADDLE_W  = 6'd4;
  localparam logic [5:0]  PADDLE_H  = 6'd32;
  localparam logic [5:0]  BALL_SIZE = 6'd4;
  localparam logic [9:0]  P1_X      = 10'd8;
  localparam logic [9:0]  P2_X      = 10'd308;

  localparam logic [2:0]  FG_COLOR  = 3'b111;
  localparam logic [2:0]  BG_COLOR  = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    ERASE_BALL,
    ERASE_P1,
    ERASE_P2,
    DRAW_P1,
    DRAW_P2,
    DRAW_BALL,
    FINISH
  } draw_state_t;

  // Fixed redraw order: erase everything old, then paint paddles, ball last.
  function automatic draw_state_t next_rect(input draw_state_t s);
    draw_state_t n;
    n = FINISH;
    case (s)
      ERASE_BALL: n = ERASE_P1;
      ERASE_P1:   n = ERASE_P2;
      ERASE_P2:   n = DRAW_P1;
      DRAW_P1:    n = DRAW_P2;
      DRAW_P2:    n = DRAW_BALL;
      default:    n = FINISH;
    endcase
    return n;
  endfunction

  function automatic logic is_erase(input draw_state_t s);
    return (s == ERASE_BALL) || (s == ERASE_P1) || (s == ERASE_P2);
  endfunction

  function automatic logic is_ball(input draw_state_t s);
    return (s == ERASE_BALL) || (s == DRAW_BALL);
  endfunction

  function automatic logic is_rect(input draw_state_t s);
    return (s != IDLE) && (s != FINISH);
  endfunction

endpackage

// File: rtl/pong_draw_sequencer_rect_scanner.sv
// Row-major rectangle walker: emits one pixel per start/step with screen clipping.
// The counters hold the next pixel to emit; start forces pixel (0,0) of a fresh rectangle.
module rect_scanner
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step,
  input  logic [9:0] origin_x,
  input  logic [8:0] origin_y,
  input  logic [5:0] w,
  input  logic [5:0] h,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       valid,
  output logic       last
);

  logic [5:0]  cx;
  logic [5:0]  cy;
  logic [5:0]  ptr_x;
  logic [5:0]  ptr_y;
  logic [10:0] sum_x;
  logic [10:0] sum_y;
  logic        end_of_row;

  always_comb begin
    ptr_x      = start ? 6'd0 : cx;
    ptr_y      = start ? 6'd0 : cy;
    sum_x      = {1'b0, origin_x} + {5'b0, ptr_x};
    sum_y      = {2'b0, origin_y} + {5'b0, ptr_y};
    x          = sum_x[9:0];
    y          = sum_y[8:0];
    end_of_row = (ptr_x == (w - 6'd1));
    last       = end_of_row && (ptr_y == (h - 6'd1));
    // Off-screen pixels still take their cycle, they just never reach the adapter.
    valid      = (start || step) && (sum_x < SCREEN_W) && (sum_y < SCREEN_H);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx <= 6'd0;
      cy <= 6'd0;
    end else if (start || step) begin
      if (last) begin
        cx <= 6'd0;
        cy <= 6'd0;
      end else if (end_of_row) begin
        cx <= 6'd0;
        cy <= ptr_y + 6'd1;
      end else begin
        cx <= ptr_x + 6'd1;
        cy <= ptr_y;
      end
    end
  end

endmodule

// File: rtl/pong_draw_sequencer.sv
// Frame-rate draw controller: erases last frame's objects and paints the new ones
// into the vga_adapter write port, one registered pixel per clock.
module pong_draw_sequencer
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [8:0] p1_y,
  input  logic [8:0] p2_y,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [2:0] color,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  draw_state_t state;
  draw_state_t state_next;
  draw_state_t target;

  logic [8:0] new_p1_y, new_p2_y, new_ball_y;
  logic [9:0] new_ball_x;
  logic [8:0] old_p1_y, old_p2_y, old_ball_y;
  logic [9:0] old_ball_x;
  logic       old_valid;

  logic [8:0] src_p1_y, src_p2_y, src_ball_y;
  logic [9:0] src_ball_x;

  logic       accept;
  logic       scan_step;
  logic       emit;
  logic [9:0] origin_x;
  logic [8:0] origin_y;
  logic [5:0] rect_w;
  logic [5:0] rect_h;
  logic [9:0] scan_x;
  logic [8:0] scan_y;
  logic       scan_valid;
  logic       scan_last;

  // The accepting IDLE cycle already emits pixel 0 of the first rectangle, so the
  // target rectangle and the "new" origins come straight from the inputs there.
  always_comb begin
    accept    = (state == IDLE) && frame_tick;
    scan_step = is_rect(state);
    emit      = accept || scan_step;

    target = state;
    if (state == IDLE) begin
      target = old_valid ? ERASE_BALL : DRAW_P1;
    end

    if (state == IDLE) begin
      src_p1_y   = p1_y;
      src_p2_y   = p2_y;
      src_ball_x = ball_x;
      src_ball_y = ball_y;
    end else begin
      src_p1_y   = new_p1_y;
      src_p2_y   = new_p2_y;
      src_ball_x = new_ball_x;
      src_ball_y = new_ball_y;
    end

    origin_x = 10'd0;
    origin_y = 9'd0;
    case (target)
      ERASE_BALL: begin origin_x = old_ball_x; origin_y = old_ball_y; end
      ERASE_P1:   begin origin_x = P1_X;       origin_y = old_p1_y;   end
      ERASE_P2:   begin origin_x = P2_X;       origin_y = old_p2_y;   end
      DRAW_P1:    begin origin_x = P1_X;       origin_y = src_p1_y;   end
      DRAW_P2:    begin origin_x = P2_X;       origin_y = src_p2_y;   end
      DRAW_BALL:  begin origin_x = src_ball_x; origin_y = src_ball_y; end
      default:    begin origin_x = 10'd0;      origin_y = 9'd0;       end
    endcase

    rect_w = is_ball(target) ? BALL_SIZE : PADDLE_W;
    rect_h = is_ball(target) ? BALL_SIZE : PADDLE_H;
  end

  rect_scanner u_scanner (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .step     (scan_step),
    .origin_x (origin_x),
    .origin_y (origin_y),
    .w        (rect_w),
    .h        (rect_h),
    .x        (scan_x),
    .y        (scan_y),
    .valid    (scan_valid),
    .last     (scan_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_next = old_valid ? ERASE_BALL : DRAW_P1;
        end
      end
      FINISH: state_next = IDLE;
      default: begin
        if (scan_last) begin
          state_next = next_rect(state);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x       <= 10'd0;
      y       <= 9'd0;
      color   <= 3'd0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      x       <= emit ? scan_x : 10'd0;
      y       <= emit ? scan_y : 9'd0;
      color   <= emit ? (is_erase(target) ? BG_COLOR : FG_COLOR) : 3'd0;
      plot    <= scan_valid;
      busy    <= accept || (state != IDLE);
      done    <= (state == FINISH);
      overrun <= frame_tick && (state != IDLE);
    end
  end

  // Positions are frozen at the tick; FINISH hands them over as next frame's erase set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      new_p1_y   <= 9'd0;
      new_p2_y   <= 9'd0;
      new_ball_x <= 10'd0;
      new_ball_y <= 9'd0;
      old_p1_y   <= 9'd0;
      old_p2_y   <= 9'd0;
      old_ball_x <= 10'd0;
      old_ball_y <= 9'd0;
      old_valid  <= 1'b0;
    end else begin
      if (accept) begin
        new_p1_y   <= p1_y;
        new_p2_y   <= p2_y;
        new_ball_x <= ball_x;
        new_ball_y <= ball_y;
      end
      if (state == FINISH) begin
        old_p1_y   <= new_p1_y;
        old_p2_y   <= new_p2_y;
        old_ball_x <= new_ball_x;
        old_ball_y <= new_ball_y;
        old_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pong_draw_sequencer.sv
// Self-checking bench: a frame-level pixel model queues the expected write stream,
// and one compare process checks the DUT against it every cycle.
module tb_pong_draw_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic [8:0] p1_y = 9'd0;
  logic [8:0] p2_y = 9'd0;
  logic [9:0] ball_x = 10'd0;
  logic [8:0] ball_y = 9'd0;
  logic [9:0] x;
  logic [8:0] y;
  logic [2:0] color;
  logic       plot, busy, done, overrun;

  always #5 clk = ~clk;

  pong_draw_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .x          (x),
    .y          (y),
    .color      (color),
    .plot       (plot),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] c;
    logic       plot;
    logic       done;
    logic       ovr;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  int oldValid = 0;
  int oldP1 = 0, oldP2 = 0, oldBx = 0, oldBy = 0;

  int          obsIdx, obsPlots, obsBg, obsBgBall, obsDoneCycle, obsOvr, obsTailPlots;
  int          lastHitIdx;
  logic [2:0]  lastHitColor;
  logic [21:0] firstPix, pix272;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act === expv) passCount++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, expv);
  endtask

  task automatic pushRect(input int ox, input int oy, input int w, input int h, input logic [2:0] c);
    exp_t e;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        int xx, yy;
        xx     = ox + k;
        yy     = oy + r;
        e.x    = xx[9:0];
        e.y    = yy[8:0];
        e.c    = c;
        e.plot = (xx < 320) && (yy < 240);
        e.done = 1'b0;
        e.ovr  = 1'b0;
        expQ.push_back(e);
      end
    end
  endtask

  task automatic buildFrame(input int p1, input int p2, input int bx, input int by);
    exp_t e;
    if (oldValid != 0) begin
      pushRect(oldBx, oldBy, 4, 4, 3'b000);
      pushRect(8, oldP1, 4, 32, 3'b000);
      pushRect(308, oldP2, 4, 32, 3'b000);
    end
    pushRect(8, p1, 4, 32, 3'b111);
    pushRect(308, p2, 4, 32, 3'b111);
    pushRect(bx, by, 4, 4, 3'b111);
    e = '{x: 10'd0, y: 9'd0, c: 3'd0, plot: 1'b0, done: 1'b1, ovr: 1'b0};
    expQ.push_back(e);
    oldValid = 1;
    oldP1 = p1; oldP2 = p2; oldBx = bx; oldBy = by;
  endtask

  task automatic applyStimulus(input int p1, input int p2, input int bx, input int by,
                               output int qlen, output logic [21:0] firstExp);
    @(negedge clk);
    p1_y   = 9'(p1);
    p2_y   = 9'(p2);
    ball_x = 10'(bx);
    ball_y = 9'(by);
    buildFrame(p1, p2, bx, by);
    qlen     = expQ.size();
    firstExp = {expQ[0].x, expQ[0].y, expQ[0].c};
    obsIdx = 0; obsPlots = 0; obsBg = 0; obsBgBall = 0; obsDoneCycle = 0;
    obsOvr = 0; obsTailPlots = 0; lastHitIdx = -1; lastHitColor = 3'd0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 3000 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      checkOutput({name, "_timeout"}, expQ.size(), 0);
      expQ.delete();
    end
    @(negedge clk);
  endtask

  // Per-cycle comparison against the queued model plus observation counters.
  always begin : compare
    exp_t e;
    logic [25:0] a, ev;
    @(posedge clk);
    #1;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      obsIdx++;
      a  = {e.plot ? x : 10'd0, e.plot ? y : 9'd0, e.plot ? color : 3'd0, plot, done, busy, overrun};
      ev = {e.plot ? e.x : 10'd0, e.plot ? e.y : 9'd0, e.plot ? e.c : 3'd0, e.plot, e.done, 1'b1, e.ovr};
      checkOutput("pixel_seq", a, ev);
      if (plot) begin
        obsPlots++;
        if (color == 3'd0) obsBg++;
        if (obsIdx <= 16 && color == 3'd0 && x >= 160 && x <= 163 && y >= 120 && y <= 123) obsBgBall++;
        if (x == 10'd8 && y == 9'd100) begin
          lastHitIdx   = obsIdx - 1;
          lastHitColor = color;
        end
        if (obsIdx >= 529 && obsIdx <= 544) obsTailPlots++;
      end
      if (obsIdx == 1)   firstPix = {x, y, color};
      if (obsIdx == 273) pix272   = {x, y, color};
      if (done)    obsDoneCycle = obsIdx;
      if (overrun) obsOvr++;
    end else begin
      checkOutput("idle_outputs", {28'd0, plot, done, busy, overrun}, 0);
    end
  end

  initial begin
    int          qlen;
    logic [21:0] fexp;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {x, y, color, plot, busy, done, overrun}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // First frame: nothing to erase.
    applyStimulus(100, 50, 160, 120, qlen, fexp);
    checkOutput("model_len_a", qlen, 273);
    checkOutput("model_first_a", fexp, {10'd8, 9'd100, 3'd7});
    waitDone("frame_a");
    checkOutput("first_pixel_a", firstPix, {10'd8, 9'd100, 3'd7});
    checkOutput("plots_a", obsPlots, 272);
    checkOutput("done_cycle_a", obsDoneCycle, 273);
    checkOutput("bg_writes_a", obsBg, 0);

    // Second frame with a mid-redraw tick and input change that must be ignored.
    applyStimulus(104, 50, 160, 120, qlen, fexp);
    checkOutput("model_len_b", qlen, 545);
    checkOutput("model_first_b", fexp, {10'd160, 9'd120, 3'd0});
    repeat (9) @(negedge clk);
    frame_tick = 1'b1;
    p1_y       = 9'd200;
    expQ[0].ovr = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    waitDone("frame_b");
    checkOutput("bg_ball_first16_b", obsBgBall, 16);
    checkOutput("plots_b", obsPlots, 544);
    checkOutput("p1_draw_start_b", pix272, {10'd8, 9'd104, 3'd7});
    checkOutput("overrun_count_b", obsOvr, 1);
    checkOutput("done_cycle_b", obsDoneCycle, 545);

    // Ball at the bottom-right corner: only 4 of its 16 pixels are on screen.
    applyStimulus(104, 50, 318, 238, qlen, fexp);
    waitDone("frame_c");
    checkOutput("ball_clip_plots_c", obsTailPlots, 4);
    checkOutput("plots_c", obsPlots, 532);
    checkOutput("done_cycle_c", obsDoneCycle, 545);

    // Abort at pixel 50 of DRAW_P1 (after the 272-pixel erase phase).
    applyStimulus(120, 60, 100, 100, qlen, fexp);
    repeat (322) @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    oldValid = 0;
    #1;
    checkOutput("abort_outputs", {x, y, color, plot, busy, done, overrun}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // After abort no erase; ball overlaps paddle 1 and must be written last.
    applyStimulus(100, 50, 8, 100, qlen, fexp);
    checkOutput("model_len_e", qlen, 273);
    waitDone("frame_e");
    checkOutput("plots_e", obsPlots, 272);
    checkOutput("done_cycle_e", obsDoneCycle, 273);
    checkOutput("overlap_last_idx_e", lastHitIdx, 256);
    checkOutput("overlap_color_e", lastHitColor, 3'd7);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
